// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, operand queries, CDB capture, in-order commit and mispredict flush.
// Optional ROB_BYPASS_EN: operand queries forward a matching same-cycle CDB broadcast.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH       = 4,
  parameter int unsigned ID_WIDTH        = 32,
  parameter int unsigned REG_WIDTH       = 5,
  parameter int unsigned INST_TYPE_WIDTH = 6,
  parameter int unsigned ADDRESS_WIDTH   = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       dispatcher_rob_en_in,
  input  logic [INST_TYPE_WIDTH-1:0] dispatcher_rob_opcode_in,
  input  logic [REG_WIDTH-1:0]       dispatcher_rob_dest_in,
  input  logic [ADDRESS_WIDTH-1:0]   dispatcher_rob_target_in,
  input  logic [ADDRESS_WIDTH-1:0]   dispatcher_rob_pc_in,
  input  logic                       dispatcher_rob_taken_in,
  output logic [ROB_WIDTH-1:0]       rob_dispatcher_b_out,
  output logic                       rob_full_out,
  input  logic [ROB_WIDTH-1:0]       dispatcher_rob_rs_h_in,
  input  logic [ROB_WIDTH-1:0]       dispatcher_rob_rt_h_in,
  output logic                       rob_dispatcher_rs_ready_out,
  output logic                       rob_dispatcher_rt_ready_out,
  output logic [ID_WIDTH-1:0]        rob_dispatcher_rs_value_out,
  output logic [ID_WIDTH-1:0]        rob_dispatcher_rt_value_out,
  input  logic                       cdb_en_in,
  input  logic [ROB_WIDTH-1:0]       cdb_tag_in,
  input  logic [ID_WIDTH-1:0]        cdb_value_in,
  input  logic                       cdb_taken_in,
  output logic                       rob_regfile_en_out,
  output logic [REG_WIDTH-1:0]       rob_regfile_rd_out,
  output logic [ID_WIDTH-1:0]        rob_regfile_value_out,
  output logic [ROB_WIDTH-1:0]       rob_regfile_reorder_out,
  output logic                       rob_store_en_out,
  output logic [ROB_WIDTH-1:0]       rob_store_tag_out,
  output logic                       rob_bp_en_out,
  output logic [ADDRESS_WIDTH-1:0]   rob_bp_pc_out,
  output logic                       rob_bp_taken_out,
  output logic                       rob_flush_out,
  output logic [ADDRESS_WIDTH-1:0]   rob_flush_pc_out
);
  localparam int unsigned DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] TAG_FIRST = ROB_WIDTH'(1);
  localparam logic [ROB_WIDTH-1:0] TAG_LAST  = ROB_WIDTH'(DEPTH - 1);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_BEQ  = INST_TYPE_WIDTH'(5);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_BGEU = INST_TYPE_WIDTH'(10);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SB   = INST_TYPE_WIDTH'(16);
  localparam logic [INST_TYPE_WIDTH-1:0] OP_SW   = INST_TYPE_WIDTH'(18);

  logic [ROB_WIDTH-1:0]       head_q, tail_q, count_q;
  logic [DEPTH-1:0]           valid_q, ready_q, pred_q, act_q;
  logic [INST_TYPE_WIDTH-1:0] op_q     [DEPTH];
  logic [REG_WIDTH-1:0]       dest_q   [DEPTH];
  logic [ADDRESS_WIDTH-1:0]   pc_q     [DEPTH];
  logic [ADDRESS_WIDTH-1:0]   target_q [DEPTH];
  logic [ID_WIDTH-1:0]        value_q  [DEPTH];

  logic [INST_TYPE_WIDTH-1:0] head_op;
  logic full_c, commit_c, branch_c, store_c, mispredict_c, alloc_c, wb_c;

  function automatic logic [ROB_WIDTH-1:0] tag_next(input logic [ROB_WIDTH-1:0] t);
    return (t == TAG_LAST) ? TAG_FIRST : t + TAG_FIRST;
  endfunction

  assign rob_dispatcher_b_out = tail_q;
  assign rob_full_out         = full_c;

  // Commit, allocate and writeback qualification; a flush overrides allocate and writeback.
  always_comb begin
    head_op      = op_q[head_q];
    full_c       = (count_q == TAG_LAST);
    commit_c     = rdy_in & valid_q[head_q] & ready_q[head_q];
    branch_c     = (head_op >= OP_BEQ) && (head_op <= OP_BGEU);
    store_c      = (head_op >= OP_SB) && (head_op <= OP_SW);
    mispredict_c = commit_c & branch_c & (act_q[head_q] != pred_q[head_q]);
    alloc_c      = rdy_in & dispatcher_rob_en_in & (~full_c | commit_c) & ~mispredict_c;
    wb_c         = rdy_in & cdb_en_in & (cdb_tag_in != '0) & valid_q[cdb_tag_in] & ~mispredict_c;
  end

  // Operand readiness queries; tag 0 never reports ready.
  always_comb begin
    rob_dispatcher_rs_ready_out = (dispatcher_rob_rs_h_in != '0) &
                                  valid_q[dispatcher_rob_rs_h_in] & ready_q[dispatcher_rob_rs_h_in];
    rob_dispatcher_rs_value_out = value_q[dispatcher_rob_rs_h_in];
    rob_dispatcher_rt_ready_out = (dispatcher_rob_rt_h_in != '0) &
                                  valid_q[dispatcher_rob_rt_h_in] & ready_q[dispatcher_rob_rt_h_in];
    rob_dispatcher_rt_value_out = value_q[dispatcher_rob_rt_h_in];
`ifdef ROB_BYPASS_EN
    if (cdb_en_in && (dispatcher_rob_rs_h_in != '0) && (cdb_tag_in == dispatcher_rob_rs_h_in)) begin
      rob_dispatcher_rs_ready_out = 1'b1;
      rob_dispatcher_rs_value_out = cdb_value_in;
    end
    if (cdb_en_in && (dispatcher_rob_rt_h_in != '0) && (cdb_tag_in == dispatcher_rob_rt_h_in)) begin
      rob_dispatcher_rt_ready_out = 1'b1;
      rob_dispatcher_rt_value_out = cdb_value_in;
    end
`endif
  end

  // Pointers and per-entry status; allocation at a just-committed slot wins over its release.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q  <= TAG_FIRST;
      tail_q  <= TAG_FIRST;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
    end else if (rdy_in) begin
      if (mispredict_c) begin
        head_q  <= TAG_FIRST;
        tail_q  <= TAG_FIRST;
        count_q <= '0;
        valid_q <= '0;
      end else begin
        if (commit_c) begin
          valid_q[head_q] <= 1'b0;
          head_q          <= tag_next(head_q);
        end
        if (wb_c) ready_q[cdb_tag_in] <= 1'b1;
        if (alloc_c) begin
          valid_q[tail_q] <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= tag_next(tail_q);
        end
        if (alloc_c && !commit_c)      count_q <= count_q + ROB_WIDTH'(1);
        else if (!alloc_c && commit_c) count_q <= count_q - ROB_WIDTH'(1);
      end
    end
  end

  // Entry payload; meaningful only while the matching valid/ready bit is set.
  always_ff @(posedge clk_in) begin
    if (alloc_c) begin
      op_q[tail_q]     <= dispatcher_rob_opcode_in;
      dest_q[tail_q]   <= dispatcher_rob_dest_in;
      pc_q[tail_q]     <= dispatcher_rob_pc_in;
      target_q[tail_q] <= dispatcher_rob_target_in;
      pred_q[tail_q]   <= dispatcher_rob_taken_in;
    end
    if (wb_c) begin
      value_q[cdb_tag_in] <= cdb_value_in;
      act_q[cdb_tag_in]   <= cdb_taken_in;
    end
  end

  // Registered commit pulses, zero whenever nothing commits.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rob_regfile_en_out      <= 1'b0;
      rob_regfile_rd_out      <= '0;
      rob_regfile_value_out   <= '0;
      rob_regfile_reorder_out <= '0;
      rob_store_en_out        <= 1'b0;
      rob_store_tag_out       <= '0;
      rob_bp_en_out           <= 1'b0;
      rob_bp_pc_out           <= '0;
      rob_bp_taken_out        <= 1'b0;
      rob_flush_out           <= 1'b0;
      rob_flush_pc_out        <= '0;
    end else begin
      rob_regfile_en_out      <= commit_c & ~branch_c & ~store_c;
      rob_regfile_rd_out      <= (commit_c & ~branch_c & ~store_c) ? dest_q[head_q] : '0;
      rob_regfile_value_out   <= (commit_c & ~branch_c & ~store_c) ? value_q[head_q] : '0;
      rob_regfile_reorder_out <= (commit_c & ~branch_c & ~store_c) ? head_q : '0;
      rob_store_en_out        <= commit_c & store_c;
      rob_store_tag_out       <= (commit_c & store_c) ? head_q : '0;
      rob_bp_en_out           <= commit_c & branch_c;
      rob_bp_pc_out           <= (commit_c & branch_c) ? pc_q[head_q] : '0;
      rob_bp_taken_out        <= commit_c & branch_c & act_q[head_q];
      rob_flush_out           <= mispredict_c;
      rob_flush_pc_out        <= !mispredict_c ? '0 :
                                 act_q[head_q] ? target_q[head_q] : pc_q[head_q] + ADDRESS_WIDTH'(4);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_reorder_buffer;
  localparam int NT = 15;
  localparam logic [5:0] OP_LUI = 6'd1, OP_BEQ = 6'd5, OP_SW = 6'd18, OP_ADDI = 6'd19;

  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b0;
  logic        en = 1'b0, pred = 1'b0;
  logic [5:0]  opcode = '0;
  logic [4:0]  dest = '0;
  logic [31:0] target = '0, pc = '0;
  logic [3:0]  b_out, rs_h = '0, rt_h = '0, cdb_tag = '0;
  logic        full, rs_ready, rt_ready, cdb_en = 1'b0, cdb_taken = 1'b0;
  logic [31:0] rs_value, rt_value, cdb_value = '0;
  logic        reg_en, st_en, bp_en, bp_taken, fl_en;
  logic [4:0]  reg_rd;
  logic [31:0] reg_value, bp_pc, fl_pc;
  logic [3:0]  reg_tag, st_tag;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .dispatcher_rob_en_in(en), .dispatcher_rob_opcode_in(opcode), .dispatcher_rob_dest_in(dest),
    .dispatcher_rob_target_in(target), .dispatcher_rob_pc_in(pc), .dispatcher_rob_taken_in(pred),
    .rob_dispatcher_b_out(b_out), .rob_full_out(full),
    .dispatcher_rob_rs_h_in(rs_h), .dispatcher_rob_rt_h_in(rt_h),
    .rob_dispatcher_rs_ready_out(rs_ready), .rob_dispatcher_rt_ready_out(rt_ready),
    .rob_dispatcher_rs_value_out(rs_value), .rob_dispatcher_rt_value_out(rt_value),
    .cdb_en_in(cdb_en), .cdb_tag_in(cdb_tag), .cdb_value_in(cdb_value), .cdb_taken_in(cdb_taken),
    .rob_regfile_en_out(reg_en), .rob_regfile_rd_out(reg_rd), .rob_regfile_value_out(reg_value),
    .rob_regfile_reorder_out(reg_tag), .rob_store_en_out(st_en), .rob_store_tag_out(st_tag),
    .rob_bp_en_out(bp_en), .rob_bp_pc_out(bp_pc), .rob_bp_taken_out(bp_taken),
    .rob_flush_out(fl_en), .rob_flush_pc_out(fl_pc)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int tag; logic [5:0] op; logic [4:0] dest; logic [31:0] pc, target, value;
    bit pred, act, done;
  } ent_t;
  typedef struct {
    int when; logic [3:0] ens; logic [4:0] rd; logic [31:0] value; int tag;
    logic [31:0] bp_pc; bit bp_taken; logic [31:0] fl_pc;
  } exp_t;

  ent_t rob[$];
  exp_t exp_q[$];
  int next_tag = 1;
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic int find(input int tag);
    for (int i = 0; i < rob.size(); i++) if (rob[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic void query(input logic [3:0] h, output bit r, output logic [31:0] v);
    int i = find(int'(h));
    r = 0; v = '0;
    if (h != 0 && i >= 0 && rob[i].done) begin r = 1; v = rob[i].value; end
`ifdef ROB_BYPASS_EN
    if (h != 0 && cdb_en && cdb_tag == h) begin r = 1; v = cdb_value; end
`endif
  endfunction

  // Model of one clock edge with rdy_in high: commit from the oldest entry, then writeback, then allocate.
  task automatic model_edge();
    int hsz = rob.size();
    bit commit = (hsz > 0) && rob[0].done;
    bit misp = 0;
    exp_t e;
    if (commit) begin
      ent_t h = rob[0];
      bit br = (h.op >= 6'd5 && h.op <= 6'd10);
      bit st = (h.op >= 6'd16 && h.op <= 6'd18);
      misp = br && (h.act != h.pred);
      e.when = cyc + 1; e.rd = h.dest; e.value = h.value; e.tag = h.tag;
      e.bp_pc = h.pc; e.bp_taken = h.act;
      e.fl_pc = h.act ? h.target : h.pc + 32'd4;
      e.ens = {!br && !st, st, br, misp};
      exp_q.push_back(e);
    end
    if (misp) begin
      rob.delete();
      next_tag = 1;
      return;
    end
    if (cdb_en) begin
      int i = find(int'(cdb_tag));
      if (i >= 0) begin rob[i].done = 1; rob[i].value = cdb_value; rob[i].act = cdb_taken; end
    end
    if (commit) void'(rob.pop_front());
    if (en && (hsz < NT || commit)) begin
      ent_t n;
      n.tag = next_tag; n.op = opcode; n.dest = dest; n.pc = pc; n.target = target;
      n.pred = pred; n.act = 0; n.done = 0; n.value = '0;
      rob.push_back(n);
      next_tag = next_tag % NT + 1;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic do_cycle();
    bit r; logic [31:0] v;
    #1;
    chk("b_out", 32'(b_out), 32'(next_tag));
    chk("full", 32'(full), 32'(rob.size() == NT));
    query(rs_h, r, v);
    chk("rs_ready", 32'(rs_ready), 32'(r));
    if (r) chk("rs_value", rs_value, v);
    query(rt_h, r, v);
    chk("rt_ready", 32'(rt_ready), 32'(r));
    if (r) chk("rt_value", rt_value, v);
    if (rdy_in) model_edge();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rdy_in = 1; en = 0; cdb_en = 0; rs_h = '0; rt_h = '0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic alloc(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] p,
                       input logic [31:0] t, input bit pr);
    idle();
    en = 1; opcode = op; dest = rd; pc = p; target = t; pred = pr;
    do_cycle();
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input bit tk);
    idle();
    cdb_en = 1; cdb_tag = tag; cdb_value = val; cdb_taken = tk;
    do_cycle();
  endtask

  task automatic do_reset();
    #2;
    rst_in = 1; idle(); rdy_in = 0;
    rob.delete(); exp_q.delete(); next_tag = 1;
    @(negedge clk_in);
    #1;
    chk("rst_b_out", 32'(b_out), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pulses", 32'({reg_en, st_en, bp_en, fl_en}), 32'd0);
    chk("rst_data", reg_value | fl_pc | bp_pc, 32'd0);
    @(negedge clk_in);
    rst_in = 0;
  endtask

  // Monitor: every commit pulse must match the oldest outstanding expectation in the same cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        while (exp_q.size() > 0 && exp_q[0].when < cyc) begin
          e = exp_q.pop_front();
          chk("missed_commit", 32'd0, 32'(e.tag));
        end
        if (exp_q.size() > 0 && exp_q[0].when == cyc) begin
          e = exp_q.pop_front();
          chk("commit_kind", 32'({reg_en, st_en, bp_en, fl_en}), 32'(e.ens));
          if (e.ens[3]) begin
            chk("reg_rd", 32'(reg_rd), 32'(e.rd));
            chk("reg_value", reg_value, e.value);
            chk("reg_tag", 32'(reg_tag), 32'(e.tag));
          end
          if (e.ens[2]) chk("store_tag", 32'(st_tag), 32'(e.tag));
          if (e.ens[1]) begin
            chk("bp_pc", bp_pc, e.bp_pc);
            chk("bp_taken", 32'(bp_taken), 32'(e.bp_taken));
          end
          if (e.ens[0]) chk("flush_pc", fl_pc, e.fl_pc);
        end else if (reg_en | st_en | bp_en | fl_en) begin
          chk("spurious_commit", 32'({reg_en, st_en, bp_en, fl_en}), 32'd0);
        end
      end
    end
  end

  initial begin
    @(negedge clk_in);
    do_reset();

    // Fill all 15 tags, then an en while full is dropped.
    for (int i = 0; i < NT; i++) alloc(OP_ADDI, 5'(i), 32'(i * 4), '0, 0);
    alloc(OP_ADDI, 5'd9, 32'h40, '0, 0);
    chk("full_after_16", 32'(full), 32'd1);
    chk("tail_wrapped", 32'(b_out), 32'd1);

    // Plain ALU result commits to the regfile.
    do_reset();
    alloc(OP_ADDI, 5'd5, 32'h0, 32'h0, 0);
    cdb(4'd1, 32'h2A, 0);
    idle_cycles(3);

    // Mispredicted branch flushes; the same-cycle allocation is discarded.
    do_reset();
    alloc(OP_BEQ, 5'd0, 32'h100, 32'h140, 0);
    alloc(OP_ADDI, 5'd3, 32'h104, 32'h0, 0);
    cdb(4'd1, 32'h0, 1);
    alloc(OP_ADDI, 5'd4, 32'h108, 32'h0, 0);
    idle_cycles(2);
    chk("tag_after_flush", 32'(b_out), 32'd1);

    // Full buffer: commit and allocate in one cycle reuses tag 1.
    do_reset();
    for (int i = 0; i < NT; i++) alloc(OP_LUI, 5'(i + 1), 32'(i * 4), '0, 0);
    cdb(4'd1, 32'h11, 0);
    alloc(OP_ADDI, 5'd7, 32'h200, 32'h0, 0);
    idle_cycles(2);
    chk("full_kept", 32'(full), 32'd1);
    chk("tag_after_reuse", 32'(b_out), 32'd2);

    // Query against a same-cycle broadcast, then the stored result.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(OP_ADDI, 5'(i + 1), 32'(i * 4), '0, 0);
    idle(); cdb_en = 1; cdb_tag = 4'd3; cdb_value = 32'h7; cdb_taken = 0; rs_h = 4'd3; rt_h = 4'd2;
    do_cycle();
    idle(); rs_h = 4'd3; do_cycle();

    // Store at the head commits through the store path only.
    do_reset();
    alloc(OP_SW, 5'd0, 32'h300, 32'h0, 0);
    cdb(4'd1, 32'h55, 0);
    idle_cycles(3);

    // Randomized traffic including stalls, flushes, stray broadcasts and dropped allocations.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rdy_in    = ($urandom % 10) != 0;
      en        = ($urandom % 10) < 6;
      opcode    = 6'($urandom_range(0, 40));
      dest      = 5'($urandom);
      pc        = $urandom & 32'hFFFF_FFFC;
      target    = $urandom & 32'hFFFF_FFFC;
      pred      = 1'($urandom);
      cdb_value = $urandom;
      cdb_taken = 1'($urandom);
      rs_h      = 4'($urandom);
      rt_h      = 4'($urandom);
      cdb_en    = 0;
      if ($urandom % 2 == 1) begin
        cdb_en = 1;
        if (rob.size() > 0 && ($urandom % 100) < 85)
          cdb_tag = 4'(rob[$urandom_range(0, rob.size() - 1)].tag);
        else
          cdb_tag = 4'($urandom);
      end
      do_cycle();
    end
    idle_cycles(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer for the Tomasulo core. It is the responder side of the dispatcher–ROB interface:
- allocates the destination tag for each dispatched instruction;
- answers the dispatcher's two operand-readiness queries;
- captures CDB results;
- commits in order to the regfile, the store path and the branch predictor;
- flushes the pipeline on a branch mispredict.

Parameters:
ROB_WIDTH, 4, tag width; usable tags 1..2^ROB_WIDTH-1 (tag 0 means "no dependency")
ID_WIDTH, 32, data value width
REG_WIDTH, 5, architectural register index width
INST_TYPE_WIDTH, 6, opcode encoding width (constant.vh encoding)
ADDRESS_WIDTH, 32, PC width

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global stall; low = all state frozen
dispatcher_rob_en_in  input  1  allocate request
dispatcher_rob_opcode_in  input  INST_TYPE_WIDTH  opcode
dispatcher_rob_dest_in  input  REG_WIDTH  rd
dispatcher_rob_target_in  input  ADDRESS_WIDTH  predicted-taken target
dispatcher_rob_pc_in  input  ADDRESS_WIDTH  instruction PC
dispatcher_rob_taken_in  input  1  predicted direction
rob_dispatcher_b_out  output  ROB_WIDTH  tag that the next allocation receives
rob_full_out  output  1  no free entry
dispatcher_rob_rs_h_in / dispatcher_rob_rt_h_in  input  ROB_WIDTH  query tags
rob_dispatcher_rs_ready_out / rob_dispatcher_rt_ready_out  output  1  queried entry has its result
rob_dispatcher_rs_value_out / rob_dispatcher_rt_value_out  output  ID_WIDTH  queried result
cdb_en_in  input  1  result broadcast valid
cdb_tag_in  input  ROB_WIDTH  producing tag
cdb_value_in  input  ID_WIDTH  result
cdb_taken_in  input  1  actual branch outcome
rob_regfile_en_out  output  1  register commit pulse
rob_regfile_rd_out  output  REG_WIDTH  committed rd
rob_regfile_value_out  output  ID_WIDTH  committed value
rob_regfile_reorder_out  output  ROB_WIDTH  committed tag (regfile clears busy only on match)
rob_store_en_out  output  1  store commit pulse
rob_store_tag_out  output  ROB_WIDTH  committed store tag
rob_bp_en_out  output  1  predictor update pulse
rob_bp_pc_out  output  ADDRESS_WIDTH  branch PC
rob_bp_taken_out  output  1  actual outcome
rob_flush_out  output  1  mispredict flush pulse
rob_flush_pc_out  output  ADDRESS_WIDTH  redirect PC

Behaviour:
- Reset: asynchronous on rst_in high.
  - head = tail = 1, count = 0, all valid and ready bits cleared.
  - All registered outputs are 0.
- Pointer wrap: head and tail advance 1, 2, …, 2^ROB_WIDTH-1, then back to 1. Tag 0 is never allocated.
- Combinational outputs:
  - rob_dispatcher_b_out = tail.
  - rob_full_out = (count == 2^ROB_WIDTH-1).
  - Query ready = valid[h] & ready[h]; value = value[h]. A query with h = 0 returns ready = 0.
- Allocate: when rdy_in & en & !full at a clock edge:
  - entry[tail] stores opcode, dest, pc, target and predicted taken;
  - valid = 1, ready = 0; tail advances; count increments.
  - An en while full is dropped. The dispatcher must gate en on full.
- Writeback: cdb_en_in with a tag whose entry is valid sets ready = 1 and stores value and actual taken. A broadcast to an invalid entry is ignored.
- Commit: at most one entry per cycle, when valid[head] & ready[head].
  - Opcode class is taken from constant.vh.
  - Branch (BEQ..BGEU): rob_bp_* pulses.
    - If actual != predicted, rob_flush_out pulses.
    - rob_flush_pc_out = actual ? target : pc + 4.
  - Store (SB..SW): rob_store_en_out pulses with the tag.
  - Other opcodes: rob_regfile_* pulses with dest, value and tag.
  - Head advances; count decrements.
- All commit and flush outputs are registered single-cycle pulses, one cycle after the commit edge. When no commit occurs they are 0. They are held 0 while rdy_in is low.
- Flush: on the mispredict commit edge, every entry is invalidated, head = tail = 1, count = 0.
  - An allocation requested in the same cycle is discarded.
  - A CDB write in the same cycle is discarded.
- Simultaneous allocate and commit: count is unchanged; a full buffer stays allocatable in that cycle only if head commits.
- Simultaneous CDB write and commit check on the same entry: the commit happens on the next cycle (no same-cycle commit).
- rdy_in low: no allocation, writeback or commit.

Optional Feature:
ROB_BYPASS_EN
- Defined: a query whose tag equals cdb_tag_in while cdb_en_in is high returns ready = 1 and value = cdb_value_in in the same cycle.
- Undefined: queries reflect stored state only, and the reservation station catches the broadcast instead.

Test Plan:
1. Reset, then 15 allocations. Tags 1..15 are returned, rob_full_out = 1 after the 15th, and a 16th en leaves tail = 1 and count = 15.
2. Allocate ADDI rd=5 (tag 1), then CDB tag 1 value 0x2A. Next cycle rob_regfile_en_out = 1, rd = 5, value = 0x2A, reorder = 1.
3. Branch pc = 0x100, target = 0x140, predicted taken = 0, CDB taken = 1. Flush pulses with pc 0x140, rob_bp_taken_out = 1, and the following tag is 1.
4. Fill to tag 15, commit tag 1, allocate in the same cycle. The new entry receives tag 1 (wrap) and count stays 15.
5. Query rs_h = 3 while cdb_tag_in = 3 with value 0x7. With ROB_BYPASS_EN the result is ready = 1, value 0x7; without it, ready = 0 that cycle and 1 the next.
6. SW at the head becomes ready. rob_store_en_out = 1 with its tag, and rob_regfile_en_out = 0.
